// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait time-out, and sticky HALT/FAULT states.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zf,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_wren,
    output logic       pc_wren,
    output logic [2:0] pc_control,
    output logic       reg_file_wren,
    output logic       data_mem_wren,
    output logic       reg_file_rmux_sel,
    output logic       reg_file_dmux_sel,
    output logic       alu_mux_sel,
    output logic [3:0] alu_op,
    output logic       retire,
    output logic       illegal,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_RALU = 3'd0,
        C_JR   = 3'd1,
        C_ADDI = 3'd2,
        C_LW   = 3'd3,
        C_SW   = 3'd4,
        C_BEQ  = 3'd5,
        C_BNE  = 3'd6,
        C_BAD  = 3'd7
    } iclass_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    // j and halt are resolved in DECODE directly, so they map to C_BAD here.
    function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: c = C_RALU;
                    6'h08:                             c = C_JR;
                    default:                           c = C_BAD;
                endcase
            end
            6'h08:   c = C_ADDI;
            6'h23:   c = C_LW;
            6'h2B:   c = C_SW;
            6'h04:   c = C_BEQ;
            6'h05:   c = C_BNE;
            default: c = C_BAD;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
        logic [3:0] o;
        case (fn)
            6'h20:   o = 4'd0;
            6'h22:   o = 4'd1;
            6'h24:   o = 4'd2;
            6'h25:   o = 4'd3;
            6'h2A:   o = 4'd4;
            default: o = 4'd0;
        endcase
        return o;
    endfunction

    state_t     state_r, next_state_s;
    iclass_t    class_r;
    logic [3:0] ralu_op_r;
    logic [7:0] wait_cnt_r, wait_cnt_s;

    logic       imem_req_s, dmem_req_s, ir_wren_s, pc_wren_s;
    logic [2:0] pc_control_s;
    logic       rf_wren_s, dm_wren_s, rmux_s, dmux_s, alu_mux_s;
    logic [3:0] alu_op_s;
    logic       retire_s, illegal_s;

    // State, wait counter and latched instruction class.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            class_r    <= C_BAD;
            ralu_op_r  <= 4'd0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_s;
            if (state_r == S_DECODE) begin
                class_r   <= decode_class(opcode, funct);
                ralu_op_r <= r_alu_op(funct);
            end else begin
                class_r   <= class_r;
                ralu_op_r <= ralu_op_r;
            end
        end
    end

    // Next-state and per-state control outputs; the counter defaults to 0,
    // which covers clearing on ready and on entry to FETCH/MEM.
    always_comb begin
        next_state_s = state_r;
        wait_cnt_s   = 8'd0;
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        ir_wren_s    = 1'b0;
        pc_wren_s    = 1'b0;
        pc_control_s = 3'b000;
        rf_wren_s    = 1'b0;
        dm_wren_s    = 1'b0;
        rmux_s       = 1'b0;
        dmux_s       = 1'b0;
        alu_mux_s    = 1'b0;
        alu_op_s     = 4'd0;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_wren_s    = 1'b1;
                    pc_wren_s    = 1'b1;
                    pc_control_s = 3'b001;
                    next_state_s = S_DECODE;
                end else if (wait_cnt_r == TIMEOUT_LIM - 8'd1) begin
                    next_state_s = S_FAULT;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            S_DECODE: begin
                if (opcode == 6'h3F) begin
                    next_state_s = S_HALT;
                end else if (opcode == 6'h02) begin
                    pc_wren_s    = 1'b1;
                    pc_control_s = 3'b010;
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end else if (decode_class(opcode, funct) != C_BAD) begin
                    next_state_s = S_EXEC;
                end else begin
                    illegal_s    = 1'b1;
                    next_state_s = S_FETCH;
                end
            end
            S_EXEC: begin
                case (class_r)
                    C_RALU: begin
                        alu_op_s     = ralu_op_r;
                        next_state_s = S_WB;
                    end
                    C_JR: begin
                        pc_wren_s    = 1'b1;
                        pc_control_s = 3'b100;
                        retire_s     = 1'b1;
                        next_state_s = S_FETCH;
                    end
                    C_ADDI: begin
                        alu_mux_s    = 1'b1;
                        next_state_s = S_WB;
                    end
                    C_LW, C_SW: begin
                        alu_mux_s    = 1'b1;
                        next_state_s = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_op_s = 4'd1;
                        retire_s = 1'b1;
                        if ((class_r == C_BEQ) ? alu_zf : !alu_zf) begin
                            pc_wren_s    = 1'b1;
                            pc_control_s = 3'b011;
                        end else begin
                            pc_wren_s    = 1'b0;
                        end
                        next_state_s = S_FETCH;
                    end
                    default: next_state_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                alu_mux_s  = 1'b1;
                dm_wren_s  = (class_r == C_SW);
                if (dmem_ready) begin
                    retire_s     = (class_r == C_SW);
                    next_state_s = (class_r == C_SW) ? S_FETCH : S_WB;
                end else if (wait_cnt_r == TIMEOUT_LIM - 8'd1) begin
                    next_state_s = S_FAULT;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            S_WB: begin
                rf_wren_s    = 1'b1;
                rmux_s       = (class_r == C_RALU);
                dmux_s       = (class_r != C_LW);
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_HALT:  next_state_s = S_HALT;
            S_FAULT: next_state_s = S_FAULT;
            default: next_state_s = S_FETCH;
        endcase
    end

    // Reset forces every request and enable low, even mid-MEM.
    assign imem_req          = imem_req_s & ~rst;
    assign dmem_req          = dmem_req_s & ~rst;
    assign ir_wren           = ir_wren_s & ~rst;
    assign pc_wren           = pc_wren_s & ~rst;
    assign pc_control        = rst ? 3'b000 : pc_control_s;
    assign reg_file_wren     = rf_wren_s & ~rst;
    assign data_mem_wren     = dm_wren_s & ~rst;
    assign reg_file_rmux_sel = rmux_s & ~rst;
    assign reg_file_dmux_sel = dmux_s & ~rst;
    assign alu_mux_sel       = alu_mux_s & ~rst;
    assign alu_op            = rst ? 4'd0 : alu_op_s;
    assign retire            = retire_s & ~rst;
    assign illegal           = illegal_s & ~rst;
    assign halted            = (state_r == S_HALT);
    assign fault             = (state_r == S_FAULT);
    assign state             = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into an expected per-cycle
// output trace from the instruction-level rules, then replayed against the DUT.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       alu_zf, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, ir_wren, pc_wren;
    logic [2:0] pc_control;
    logic       reg_file_wren, data_mem_wren, reg_file_rmux_sel, reg_file_dmux_sel, alu_mux_sel;
    logic [3:0] alu_op;
    logic       retire, illegal, halted, fault;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zf(alu_zf),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .ir_wren(ir_wren), .pc_wren(pc_wren), .pc_control(pc_control),
        .reg_file_wren(reg_file_wren), .data_mem_wren(data_mem_wren),
        .reg_file_rmux_sel(reg_file_rmux_sel), .reg_file_dmux_sel(reg_file_dmux_sel),
        .alu_mux_sel(alu_mux_sel), .alu_op(alu_op), .retire(retire), .illegal(illegal),
        .halted(halted), .fault(fault), .state(state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, dreq, irw, pcw;
        logic [2:0] pcc;
        logic       rfw, dmw, rmux, dmux, amux;
        logic [3:0] aop;
        logic       ret, ill, hlt, flt;
    } vec_t;

    typedef struct {
        logic ir;
        logic dr;
        logic zf;
        vec_t e;
    } step_t;

    localparam int K_ILL = 0, K_HALT = 1, K_J = 2, K_R = 3, K_JR = 4,
                   K_ADDI = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9;

    int    checks = 0;
    int    errors = 0;
    step_t q[$];
    vec_t  dut_v;

    assign dut_v = {state, imem_req, dmem_req, ir_wren, pc_wren, pc_control, reg_file_wren,
                    data_mem_wren, reg_file_rmux_sel, reg_file_dmux_sel, alu_mux_sel, alu_op,
                    retire, illegal, halted, fault};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h3F: return K_HALT;
            6'h02: return K_J;
            6'h08: return K_ADDI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                    return K_R;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] r_op(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // A cycle in state st with nothing asserted; ready/zf inputs are noise.
    function automatic step_t blank_step(input logic [2:0] st);
        step_t s;
        s.ir    = 1'($urandom);
        s.dr    = 1'($urandom);
        s.zf    = 1'($urandom);
        s.e     = '0;
        s.e.st  = st;
        s.e.hlt = (st == 3'd5);
        s.e.flt = (st == 3'd6);
        return s;
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int iwait,
                         input int dwait, input logic zf);
        int    k;
        step_t s;
        k = kind_of(op, fn);
        for (int i = 0; i < iwait; i++) begin
            s = blank_step(3'd0); s.ir = 1'b0; s.e.ireq = 1'b1; q.push_back(s);
        end
        s = blank_step(3'd0); s.ir = 1'b1;
        s.e.ireq = 1'b1; s.e.irw = 1'b1; s.e.pcw = 1'b1; s.e.pcc = 3'd1;
        q.push_back(s);
        s = blank_step(3'd1);
        if (k == K_J) begin
            s.e.pcw = 1'b1; s.e.pcc = 3'd2; s.e.ret = 1'b1;
        end else if (k == K_ILL) begin
            s.e.ill = 1'b1;
        end
        q.push_back(s);
        if (k == K_HALT) begin
            for (int i = 0; i < 20; i++) q.push_back(blank_step(3'd5));
            return;
        end
        if (k == K_J || k == K_ILL) return;
        s = blank_step(3'd2); s.zf = zf;
        if (k == K_R) begin
            s.e.aop = r_op(fn);
        end else if (k == K_JR) begin
            s.e.pcw = 1'b1; s.e.pcc = 3'd4; s.e.ret = 1'b1;
        end else if (k == K_ADDI || k == K_LW || k == K_SW) begin
            s.e.amux = 1'b1;
        end else begin
            s.e.aop = 4'd1; s.e.ret = 1'b1;
            if ((k == K_BEQ && zf) || (k == K_BNE && !zf)) begin
                s.e.pcw = 1'b1; s.e.pcc = 3'd3;
            end
        end
        q.push_back(s);
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= dwait; i++) begin
                s = blank_step(3'd3);
                s.dr = (i == dwait);
                s.e.dreq = 1'b1; s.e.amux = 1'b1; s.e.dmw = (k == K_SW);
                s.e.ret = (i == dwait) && (k == K_SW);
                q.push_back(s);
            end
        end
        if (k == K_R || k == K_ADDI || k == K_LW) begin
            s = blank_step(3'd4);
            s.e.rfw = 1'b1; s.e.rmux = (k == K_R); s.e.dmux = (k != K_LW); s.e.ret = 1'b1;
            q.push_back(s);
        end
    endtask

    // Replay up to n queued cycles (all when n < 0), comparing every cycle.
    task automatic play(input logic [5:0] op, input logic [5:0] fn, input string tag, input int n);
        int cnt = 0;
        opcode = op;
        funct  = fn;
        while (q.size() > 0 && (n < 0 || cnt < n)) begin
            step_t s;
            s = q.pop_front();
            imem_ready = s.ir; dmem_ready = s.dr; alu_zf = s.zf;
            @(negedge clk);
            check_eq($sformatf("%s_c%0d", tag, cnt), 32'(dut_v), 32'(s.e));
            @(posedge clk); #1;
            cnt++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("reset", 32'(dut_v), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h08, 6'h23, 6'h2B, 6'h04,
                            6'h05, 6'h11, 6'h3A, 6'h00};
    logic [5:0] fns[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h21, 6'h00};

    initial begin
        rst = 1'b1; opcode = 6'h00; funct = 6'h00;
        alu_zf = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        do_reset();

        build(6'h00, 6'h20, 0, 0, 1'b0); play(6'h00, 6'h20, "add", -1);
        build(6'h23, 6'h00, 0, 3, 1'b0); play(6'h23, 6'h00, "lw_wait3", -1);
        build(6'h04, 6'h00, 0, 0, 1'b1); play(6'h04, 6'h00, "beq_taken", -1);
        build(6'h04, 6'h00, 0, 0, 1'b0); play(6'h04, 6'h00, "beq_not", -1);
        build(6'h11, 6'h00, 0, 0, 1'b0); play(6'h11, 6'h00, "illegal", -1);
        build(6'h08, 6'h00, 254, 2, 1'b0); play(6'h08, 6'h00, "addi_wait254", -1);

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            if (op == 6'h3F) op = 6'h00;
            build(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            play(op, fn, $sformatf("rnd%0d_op%02h_fn%02h", n, op, fn), -1);
        end

        // sw interrupted by reset on its second MEM cycle
        build(6'h2B, 6'h00, 0, 5, 1'b0);
        play(6'h2B, 6'h00, "sw_pre", 4);
        rst = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        check_eq("sw_rst_state", 32'(state), 32'd3);
        check_eq("sw_rst_dmw", 32'(data_mem_wren), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        check_eq("sw_after_state", 32'(state), 32'd0);
        check_eq("sw_after_dmw", 32'(data_mem_wren), 32'd0);
        check_eq("sw_after_dreq", 32'(dmem_req), 32'd0);
        check_eq("sw_after_ireq", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        do_reset();

        build(6'h3F, 6'h00, 1, 0, 1'b0); play(6'h3F, 6'h00, "halt", -1);
        do_reset();

        for (int i = 0; i < 255; i++) begin
            step_t s;
            s = blank_step(3'd0); s.ir = 1'b0; s.e.ireq = 1'b1; q.push_back(s);
        end
        for (int i = 0; i < 3; i++) q.push_back(blank_step(3'd6));
        play(6'h00, 6'h20, "timeout", -1);
        do_reset();

        build(6'h00, 6'h2A, 0, 0, 1'b0); play(6'h00, 6'h2A, "slt_after_fault", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max wait cycles for a memory ready before fault (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instr[31:26] from instruction register.
REQ-005 funct  input  6  instr[5:0] from instruction register.
REQ-006 alu_zf  input  1  ALU zero flag.
REQ-007 imem_ready  input  1  instruction memory ready.
REQ-008 dmem_ready  input  1  data memory ready.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 dmem_req  output  1  data memory request.
REQ-011 ir_wren  output  1  instruction register load.
REQ-012 pc_wren  output  1  PC update enable.
REQ-013 pc_control  output  3  000 hold, 001 PC+4, 010 jump, 011 branch, 100 register (jr).
REQ-014 reg_file_wren, data_mem_wren  output  1 each  register and memory write enables.
REQ-015 reg_file_rmux_sel  output  1  1 = rd (instr[15:11]), 0 = rt.
REQ-016 reg_file_dmux_sel  output  1  1 = ALU result, 0 = memory data.
REQ-017 alu_mux_sel  output  1  1 = sign-extended immediate, 0 = rt.
REQ-018 alu_op  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
REQ-019 retire, illegal  output  1 each  single-cycle pulses.
REQ-020 halted, fault  output  1 each  sticky status.
REQ-021 state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.

Function
REQ-022 FETCH: imem_req=1; when imem_ready, ir_wren=1, pc_wren=1, pc_control=001 in that cycle, next DECODE; else stay.
REQ-023 DECODE: opcode 0x3F -> HALT; 0x02 (j) -> pc_wren=1, pc_control=010, retire=1, FETCH; supported opcode -> EXEC; otherwise illegal=1, retire=0, FETCH; no register/memory write.
REQ-024 Supported: R-type 0x00 with funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x08 jr; 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne; R-type with other funct is illegal.
REQ-025 EXEC R-type ALU: alu_op per funct, alu_mux_sel=0, next WB.
REQ-026 EXEC jr: pc_wren=1, pc_control=100, retire=1, next FETCH.
REQ-027 EXEC addi/lw/sw: alu_op=ADD, alu_mux_sel=1; addi -> WB, lw/sw -> MEM.
REQ-028 EXEC beq/bne: alu_op=SUB, alu_mux_sel=0; taken (beq & zf, bne & !zf) -> pc_wren=1, pc_control=011; retire=1; next FETCH.
REQ-029 MEM: dmem_req=1, alu_op=ADD, alu_mux_sel=1 held every cycle; data_mem_wren=1 throughout for sw only; on dmem_ready sw -> FETCH with retire=1, lw -> WB.
REQ-030 WB: reg_file_wren=1 for exactly one cycle; rmux_sel=1 for R-type, 0 for addi/lw; dmux_sel=0 for lw, else 1; retire=1; next FETCH.
REQ-031 Outputs not named for a state are 0; pc_control=000 whenever pc_wren=0.
REQ-032 Ready inputs are ignored when the matching request is low.
REQ-033 Wait counter (8 bit) clears on entry to FETCH and MEM and on ready; increments each cycle request is high without ready; reaching TIMEOUT_CYCLES -> FAULT.
REQ-034 HALT sets halted=1, FAULT sets fault=1; both absorbing until rst; all requests/enables 0.
REQ-035 Latencies with zero-wait memory: R-type/addi 4 cycles, lw 5, sw 4, beq/bne/jr 3, j 2.

Reset
REQ-036 rst high at a clock edge overrides every other event: state=FETCH, counter=0, halted=0, fault=0; also mid-MEM with data_mem_wren high.
REQ-037 During rst and the following FETCH cycle all write enables are 0; imem_req=1 from first post-reset cycle.

Verification
REQ-038 add (op 0, funct 0x20), ready immediately -> states 0,1,2,4,0; reg_file_wren=1 only in WB, rmux_sel=1, dmux_sel=1.
REQ-039 lw with dmem_ready delayed 3 cycles -> MEM held 4 cycles, dmem_req=1 throughout, WB dmux_sel=0, rmux_sel=0.
REQ-040 beq with zf=1 then zf=0 -> pc_wren=1/pc_control=011 first case only; both retire in 3 cycles.
REQ-041 opcode 0x11 -> illegal pulse in DECODE, no write enables, back to FETCH; opcode 0x3F -> halted=1, state=5 held 20 cycles.
REQ-042 imem_ready held low 255 cycles -> state=6, fault=1; rst pulse -> state=0, fault=0.
REQ-043 sw, rst asserted on second MEM cycle -> next cycle state=0, data_mem_wren=0, dmem_req=0.
